// File: rtl/riscv_pkg.sv
// Shared definitions for the RISC-V pipeline: ALU op encodings, forward selects
// and default datapath widths.
package riscv_pkg;

    localparam int DEF_BITS = 64;
    localparam int DEF_REGW = 5;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_OR  = 2'b11;

    typedef enum logic [1:0] {
        FWD_REG   = 2'd0,
        FWD_EXMEM = 2'd1,
        FWD_MEMWB = 2'd2
    } fwd_sel_e;

endpackage

// File: rtl/forward_unit.sv
// Chooses the source of one EX operand: the newer EX/MEM result beats MEM/WB,
// and x0 is never forwarded.
module forward_unit
    import riscv_pkg::*;
#(
    parameter int REGW = DEF_REGW
) (
    input  logic [REGW-1:0] i_rs,
    input  logic [REGW-1:0] i_exmem_rd,
    input  logic            i_exmem_reg_write,
    input  logic [REGW-1:0] i_memwb_rd,
    input  logic            i_memwb_reg_write,
    output fwd_sel_e        o_sel
);

    logic w_exmem_hit;
    logic w_memwb_hit;

    assign w_exmem_hit = i_exmem_reg_write && (i_exmem_rd != '0) && (i_exmem_rd == i_rs);
    assign w_memwb_hit = i_memwb_reg_write && (i_memwb_rd != '0) && (i_memwb_rd == i_rs);

    always_comb begin
        o_sel = FWD_REG;
        if (w_exmem_hit) begin
            o_sel = FWD_EXMEM;
        end else if (w_memwb_hit) begin
            o_sel = FWD_MEMWB;
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand forwarding, load-use bubble insertion
// and a saturating bubble counter.
module id_ex_stage
    import riscv_pkg::*;
#(
    parameter int BITS = DEF_BITS,
    parameter int REGW = DEF_REGW,
    parameter int CNTW = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            id_valid,
    input  logic [BITS-1:0] id_rs1_data,
    input  logic [BITS-1:0] id_rs2_data,
    input  logic [BITS-1:0] id_imm,
    input  logic [REGW-1:0] id_rs1,
    input  logic [REGW-1:0] id_rs2,
    input  logic [REGW-1:0] id_rd,
    input  logic            id_alu_src,
    input  logic [1:0]      id_alu_ctrl,
    input  logic            id_reg_write,
    input  logic            id_mem_read,
    input  logic            id_mem_write,
    input  logic            id_mem_to_reg,
    input  logic            stall,
    input  logic            flush,
    input  logic [REGW-1:0] exmem_rd,
    input  logic            exmem_reg_write,
    input  logic [BITS-1:0] exmem_result,
    input  logic [REGW-1:0] memwb_rd,
    input  logic            memwb_reg_write,
    input  logic [BITS-1:0] memwb_result,
    output logic [BITS-1:0] src_a,
    output logic [BITS-1:0] src_b,
    output logic [1:0]      alu_control,
    output logic [BITS-1:0] ex_store_data,
    output logic [REGW-1:0] ex_rd,
    output logic            ex_valid,
    output logic            ex_reg_write,
    output logic            ex_mem_read,
    output logic            ex_mem_write,
    output logic            ex_mem_to_reg,
    output logic            load_use_hold,
    output logic [CNTW-1:0] bubble_count
);

    typedef struct packed {
        logic            valid;
        logic [BITS-1:0] rs1_data;
        logic [BITS-1:0] rs2_data;
        logic [BITS-1:0] imm;
        logic [REGW-1:0] rs1;
        logic [REGW-1:0] rs2;
        logic [REGW-1:0] rd;
        logic            alu_src;
        logic [1:0]      alu_ctrl;
        logic            reg_write;
        logic            mem_read;
        logic            mem_write;
        logic            mem_to_reg;
    } idex_t;

    idex_t           r_pipe;
    idex_t           w_next;
    logic [CNTW-1:0] r_bubble_count;
    fwd_sel_e        w_sel_a;
    fwd_sel_e        w_sel_b;
    logic [BITS-1:0] w_fwd_a;
    logic [BITS-1:0] w_fwd_b;
    logic            w_hold;
    logic            w_lu_bubble;

    forward_unit #(.REGW(REGW)) u_fwd_rs1 (
        .i_rs              (r_pipe.rs1),
        .i_exmem_rd        (exmem_rd),
        .i_exmem_reg_write (exmem_reg_write),
        .i_memwb_rd        (memwb_rd),
        .i_memwb_reg_write (memwb_reg_write),
        .o_sel             (w_sel_a)
    );

    forward_unit #(.REGW(REGW)) u_fwd_rs2 (
        .i_rs              (r_pipe.rs2),
        .i_exmem_rd        (exmem_rd),
        .i_exmem_reg_write (exmem_reg_write),
        .i_memwb_rd        (memwb_rd),
        .i_memwb_reg_write (memwb_reg_write),
        .o_sel             (w_sel_b)
    );

    // Bubbles carry stale rs indices as zero, but gate on valid anyway so an
    // empty slot never picks up a writeback value.
    always_comb begin
        w_fwd_a = r_pipe.rs1_data;
        w_fwd_b = r_pipe.rs2_data;
        if (r_pipe.valid) begin
            case (w_sel_a)
                FWD_EXMEM: w_fwd_a = exmem_result;
                FWD_MEMWB: w_fwd_a = memwb_result;
                default:   w_fwd_a = r_pipe.rs1_data;
            endcase
            case (w_sel_b)
                FWD_EXMEM: w_fwd_b = exmem_result;
                FWD_MEMWB: w_fwd_b = memwb_result;
                default:   w_fwd_b = r_pipe.rs2_data;
            endcase
        end
    end

    assign w_hold = r_pipe.valid && r_pipe.mem_read && (r_pipe.rd != '0) && id_valid &&
                    ((r_pipe.rd == id_rs1) || ((r_pipe.rd == id_rs2) && !id_alu_src));

    // Only a bubble that actually enters the register is counted.
    assign w_lu_bubble = w_hold && !flush && !stall;

    always_comb begin
        w_next = r_pipe;
        if (flush) begin
            w_next = '0;
        end else if (stall) begin
            w_next = r_pipe;
        end else if (w_hold) begin
            w_next = '0;
        end else begin
            w_next.valid      = id_valid;
            w_next.rs1_data   = id_rs1_data;
            w_next.rs2_data   = id_rs2_data;
            w_next.imm        = id_imm;
            w_next.rs1        = id_rs1;
            w_next.rs2        = id_rs2;
            w_next.rd         = id_rd;
            w_next.alu_src    = id_alu_src;
            w_next.alu_ctrl   = id_alu_ctrl;
            w_next.reg_write  = id_reg_write;
            w_next.mem_read   = id_mem_read;
            w_next.mem_write  = id_mem_write;
            w_next.mem_to_reg = id_mem_to_reg;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pipe         <= '0;
            r_bubble_count <= '0;
        end else begin
            r_pipe <= w_next;
            if (w_lu_bubble && (r_bubble_count != '1)) begin
                r_bubble_count <= r_bubble_count + CNTW'(1);
            end
        end
    end

    assign src_a         = w_fwd_a;
    assign src_b         = r_pipe.alu_src ? r_pipe.imm : w_fwd_b;
    assign ex_store_data = w_fwd_b;
    assign alu_control   = r_pipe.alu_ctrl;
    assign ex_rd         = r_pipe.rd;
    assign ex_valid      = r_pipe.valid;
    assign ex_reg_write  = r_pipe.reg_write;
    assign ex_mem_read   = r_pipe.mem_read;
    assign ex_mem_write  = r_pipe.mem_write;
    assign ex_mem_to_reg = r_pipe.mem_to_reg;
    assign load_use_hold = w_hold;
    assign bubble_count  = r_bubble_count;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: reset, capture, forwarding priority,
// load-use bubbles, flush/stall interplay and counter saturation.
module tb_id_ex_stage;
    import riscv_pkg::*;

    localparam int BITS = 64;
    localparam int REGW = 5;
    localparam int CNTW = 4;

    logic            clk;
    logic            rst_n;
    logic            id_valid;
    logic [BITS-1:0] id_rs1_data;
    logic [BITS-1:0] id_rs2_data;
    logic [BITS-1:0] id_imm;
    logic [REGW-1:0] id_rs1;
    logic [REGW-1:0] id_rs2;
    logic [REGW-1:0] id_rd;
    logic            id_alu_src;
    logic [1:0]      id_alu_ctrl;
    logic            id_reg_write;
    logic            id_mem_read;
    logic            id_mem_write;
    logic            id_mem_to_reg;
    logic            stall;
    logic            flush;
    logic [REGW-1:0] exmem_rd;
    logic            exmem_reg_write;
    logic [BITS-1:0] exmem_result;
    logic [REGW-1:0] memwb_rd;
    logic            memwb_reg_write;
    logic [BITS-1:0] memwb_result;
    logic [BITS-1:0] src_a;
    logic [BITS-1:0] src_b;
    logic [1:0]      alu_control;
    logic [BITS-1:0] ex_store_data;
    logic [REGW-1:0] ex_rd;
    logic            ex_valid;
    logic            ex_reg_write;
    logic            ex_mem_read;
    logic            ex_mem_write;
    logic            ex_mem_to_reg;
    logic            load_use_hold;
    logic [CNTW-1:0] bubble_count;

    int              total;
    int              bad;
    logic [CNTW-1:0] exp_bubbles;

    id_ex_stage #(.BITS(BITS), .REGW(REGW), .CNTW(CNTW)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .id_valid        (id_valid),
        .id_rs1_data     (id_rs1_data),
        .id_rs2_data     (id_rs2_data),
        .id_imm          (id_imm),
        .id_rs1          (id_rs1),
        .id_rs2          (id_rs2),
        .id_rd           (id_rd),
        .id_alu_src      (id_alu_src),
        .id_alu_ctrl     (id_alu_ctrl),
        .id_reg_write    (id_reg_write),
        .id_mem_read     (id_mem_read),
        .id_mem_write    (id_mem_write),
        .id_mem_to_reg   (id_mem_to_reg),
        .stall           (stall),
        .flush           (flush),
        .exmem_rd        (exmem_rd),
        .exmem_reg_write (exmem_reg_write),
        .exmem_result    (exmem_result),
        .memwb_rd        (memwb_rd),
        .memwb_reg_write (memwb_reg_write),
        .memwb_result    (memwb_result),
        .src_a           (src_a),
        .src_b           (src_b),
        .alu_control     (alu_control),
        .ex_store_data   (ex_store_data),
        .ex_rd           (ex_rd),
        .ex_valid        (ex_valid),
        .ex_reg_write    (ex_reg_write),
        .ex_mem_read     (ex_mem_read),
        .ex_mem_write    (ex_mem_write),
        .ex_mem_to_reg   (ex_mem_to_reg),
        .load_use_hold   (load_use_hold),
        .bubble_count    (bubble_count)
    );

    // clock / reset block
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_id();
        id_valid      = 1'b0;
        id_rs1_data   = '0;
        id_rs2_data   = '0;
        id_imm        = '0;
        id_rs1        = '0;
        id_rs2        = '0;
        id_rd         = '0;
        id_alu_src    = 1'b0;
        id_alu_ctrl   = ALU_ADD;
        id_reg_write  = 1'b0;
        id_mem_read   = 1'b0;
        id_mem_write  = 1'b0;
        id_mem_to_reg = 1'b0;
    endtask

    task automatic clear_wb();
        exmem_rd        = '0;
        exmem_reg_write = 1'b0;
        exmem_result    = '0;
        memwb_rd        = '0;
        memwb_reg_write = 1'b0;
        memwb_result    = '0;
    endtask

    // Latches a valid load writing x4 into EX.
    task automatic latch_load();
        clear_id();
        id_valid      = 1'b1;
        id_mem_read   = 1'b1;
        id_reg_write  = 1'b1;
        id_mem_to_reg = 1'b1;
        id_rd         = 5'd4;
        id_rs1        = 5'd1;
        id_rs2        = 5'd2;
        step();
    endtask

    task automatic test_reset();
        rst_n        = 1'b0;
        id_valid     = 1'b1;
        id_rs1_data  = 64'hDEAD;
        id_alu_ctrl  = ALU_SUB;
        id_reg_write = 1'b1;
        step();
        step();
        total++;
        if (ex_valid !== 1'b0) begin
            bad++; $display("FAIL reset_valid got=%0h want=0", ex_valid);
        end
        total++;
        if (alu_control !== 2'b00) begin
            bad++; $display("FAIL reset_alu_control got=%0h want=0", alu_control);
        end
        total++;
        if (bubble_count !== 4'h0) begin
            bad++; $display("FAIL reset_bubble_count got=%0h want=0", bubble_count);
        end
        total++;
        if (src_a !== 64'h0) begin
            bad++; $display("FAIL reset_src_a got=%0h want=0", src_a);
        end
        total++;
        if (ex_reg_write !== 1'b0) begin
            bad++; $display("FAIL reset_reg_write got=%0h want=0", ex_reg_write);
        end
        clear_id();
        rst_n = 1'b1;
        exp_bubbles = '0;
    endtask

    task automatic test_capture();
        clear_id();
        id_valid    = 1'b1;
        id_rs1_data = 64'd5;
        id_rs2_data = 64'd9;
        id_imm      = 64'd7;
        id_alu_src  = 1'b1;
        id_alu_ctrl = ALU_SUB;
        id_rs1      = 5'd1;
        id_rs2      = 5'd2;
        id_rd       = 5'd3;
        step();
        total++;
        if (src_a !== 64'd5) begin
            bad++; $display("FAIL capture_src_a got=%0h want=5", src_a);
        end
        total++;
        if (src_b !== 64'd7) begin
            bad++; $display("FAIL capture_src_b got=%0h want=7", src_b);
        end
        total++;
        if (alu_control !== ALU_SUB) begin
            bad++; $display("FAIL capture_alu_control got=%0h want=1", alu_control);
        end
        total++;
        if (ex_valid !== 1'b1) begin
            bad++; $display("FAIL capture_valid got=%0h want=1", ex_valid);
        end
        total++;
        if (ex_store_data !== 64'd9) begin
            bad++; $display("FAIL capture_store_data got=%0h want=9", ex_store_data);
        end
        total++;
        if (ex_rd !== 5'd3) begin
            bad++; $display("FAIL capture_rd got=%0h want=3", ex_rd);
        end
    endtask

    task automatic test_forward();
        clear_id();
        clear_wb();
        id_valid    = 1'b1;
        id_rs1      = 5'd3;
        id_rs2      = 5'd3;
        id_rs1_data = 64'h33;
        id_rs2_data = 64'h44;
        id_rd       = 5'd8;
        step();
        exmem_rd        = 5'd3;
        exmem_result    = 64'h11;
        exmem_reg_write = 1'b1;
        memwb_rd        = 5'd3;
        memwb_result    = 64'h22;
        memwb_reg_write = 1'b1;
        #1;
        total++;
        if (src_a !== 64'h11) begin
            bad++; $display("FAIL fwd_exmem_src_a got=%0h want=11", src_a);
        end
        total++;
        if (src_b !== 64'h11) begin
            bad++; $display("FAIL fwd_exmem_src_b got=%0h want=11", src_b);
        end
        total++;
        if (ex_store_data !== 64'h11) begin
            bad++; $display("FAIL fwd_exmem_store got=%0h want=11", ex_store_data);
        end
        exmem_reg_write = 1'b0;
        #1;
        total++;
        if (src_a !== 64'h22) begin
            bad++; $display("FAIL fwd_memwb_src_a got=%0h want=22", src_a);
        end
        memwb_rd = 5'd9;
        #1;
        total++;
        if (src_a !== 64'h33) begin
            bad++; $display("FAIL fwd_none_src_a got=%0h want=33", src_a);
        end
        exmem_rd        = 5'd0;
        exmem_reg_write = 1'b1;
        memwb_rd        = 5'd0;
        id_rs1          = 5'd0;
        id_rs2          = 5'd0;
        id_rs1_data     = 64'h55;
        id_rs2_data     = 64'h66;
        step();
        total++;
        if (src_a !== 64'h55) begin
            bad++; $display("FAIL fwd_x0_src_a got=%0h want=55", src_a);
        end
        total++;
        if (src_b !== 64'h66) begin
            bad++; $display("FAIL fwd_x0_src_b got=%0h want=66", src_b);
        end
        clear_wb();
    endtask

    task automatic test_load_use();
        latch_load();
        total++;
        if (ex_mem_read !== 1'b1 || ex_rd !== 5'd4) begin
            bad++; $display("FAIL lu_load_latched got=%0h/%0h want=1/4", ex_mem_read, ex_rd);
        end
        clear_id();
        id_valid = 1'b1;
        id_rs1   = 5'd5;
        id_rs2   = 5'd4;
        id_rd    = 5'd6;
        #1;
        total++;
        if (load_use_hold !== 1'b1) begin
            bad++; $display("FAIL lu_hold_rs2 got=%0h want=1", load_use_hold);
        end
        step();
        exp_bubbles = exp_bubbles + 4'd1;
        total++;
        if (ex_valid !== 1'b0) begin
            bad++; $display("FAIL lu_bubble_valid got=%0h want=0", ex_valid);
        end
        total++;
        if (bubble_count !== exp_bubbles) begin
            bad++; $display("FAIL lu_bubble_count got=%0h want=%0h", bubble_count, exp_bubbles);
        end
        total++;
        if (load_use_hold !== 1'b0 || ex_mem_read !== 1'b0) begin
            bad++; $display("FAIL lu_after_bubble got=%0h/%0h want=0/0", load_use_hold, ex_mem_read);
        end
        step();
        total++;
        if (ex_valid !== 1'b1 || ex_rd !== 5'd6) begin
            bad++; $display("FAIL lu_resume got=%0h/%0h want=1/6", ex_valid, ex_rd);
        end
        latch_load();
        clear_id();
        id_valid   = 1'b1;
        id_rs1     = 5'd5;
        id_rs2     = 5'd4;
        id_alu_src = 1'b1;
        id_rd      = 5'd6;
        #1;
        total++;
        if (load_use_hold !== 1'b0) begin
            bad++; $display("FAIL lu_imm_no_hold got=%0h want=0", load_use_hold);
        end
        step();
        total++;
        if (ex_valid !== 1'b1 || bubble_count !== exp_bubbles) begin
            bad++; $display("FAIL lu_imm_capture got=%0h/%0h want=1/%0h", ex_valid, bubble_count, exp_bubbles);
        end
    endtask

    task automatic test_flush_stall();
        latch_load();
        clear_id();
        id_valid = 1'b1;
        id_rs1   = 5'd4;
        id_rd    = 5'd6;
        stall    = 1'b1;
        #1;
        total++;
        if (load_use_hold !== 1'b1) begin
            bad++; $display("FAIL fs_hold_rs1 got=%0h want=1", load_use_hold);
        end
        step();
        total++;
        if (ex_valid !== 1'b1 || ex_rd !== 5'd4 || bubble_count !== exp_bubbles) begin
            bad++; $display("FAIL fs_stall_over_hazard got=%0h/%0h/%0h want=1/4/%0h", ex_valid, ex_rd, bubble_count, exp_bubbles);
        end
        flush = 1'b1;
        step();
        total++;
        if (ex_valid !== 1'b0 || bubble_count !== exp_bubbles) begin
            bad++; $display("FAIL fs_flush_over_stall got=%0h/%0h want=0/%0h", ex_valid, bubble_count, exp_bubbles);
        end
        flush = 1'b0;
        stall = 1'b0;
        clear_id();
        id_valid     = 1'b1;
        id_rs1_data  = 64'h77;
        id_imm       = 64'h8;
        id_alu_src   = 1'b1;
        id_alu_ctrl  = ALU_AND;
        id_rd        = 5'd7;
        id_reg_write = 1'b1;
        step();
        id_rs1_data = 64'h99;
        id_imm      = 64'h1;
        id_alu_ctrl = ALU_OR;
        id_rd       = 5'd2;
        stall       = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            total++;
            if (src_a !== 64'h77 || src_b !== 64'h8 || alu_control !== ALU_AND ||
                ex_valid !== 1'b1 || ex_rd !== 5'd7) begin
                bad++; $display("FAIL fs_stall_hold%0d got=%0h/%0h/%0h/%0h/%0h want=77/8/2/1/7",
                                i, src_a, src_b, alu_control, ex_valid, ex_rd);
            end
        end
        stall = 1'b0;
        latch_load();
        clear_id();
        id_valid = 1'b1;
        id_rs1   = 5'd4;
        flush    = 1'b1;
        step();
        total++;
        if (ex_valid !== 1'b0 || bubble_count !== exp_bubbles) begin
            bad++; $display("FAIL fs_flush_over_hazard got=%0h/%0h want=0/%0h", ex_valid, bubble_count, exp_bubbles);
        end
        flush = 1'b0;
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 17; i++) begin
            latch_load();
            clear_id();
            id_valid = 1'b1;
            id_rs1   = 5'd4;
            id_rd    = 5'd6;
            step();
            if (exp_bubbles != 4'hF) exp_bubbles = exp_bubbles + 4'd1;
            total++;
            if (bubble_count !== exp_bubbles) begin
                bad++; $display("FAIL sat_count%0d got=%0h want=%0h", i, bubble_count, exp_bubbles);
            end
        end
        total++;
        if (bubble_count !== 4'hF) begin
            bad++; $display("FAIL sat_final got=%0h want=f", bubble_count);
        end
    endtask

    task automatic test_reset_mid_hazard();
        latch_load();
        clear_id();
        id_valid = 1'b1;
        id_rs1   = 5'd4;
        #1;
        total++;
        if (load_use_hold !== 1'b1) begin
            bad++; $display("FAIL rmh_hold_before got=%0h want=1", load_use_hold);
        end
        rst_n = 1'b0;
        step();
        total++;
        if (load_use_hold !== 1'b0 || ex_valid !== 1'b0 || bubble_count !== 4'h0) begin
            bad++; $display("FAIL rmh_cleared got=%0h/%0h/%0h want=0/0/0", load_use_hold, ex_valid, bubble_count);
        end
        rst_n = 1'b1;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        exp_bubbles = '0;
        stall = 1'b0;
        flush = 1'b0;
        clear_id();
        clear_wb();
        test_reset();
        test_capture();
        test_forward();
        test_load_use();
        test_flush_stall();
        test_saturation();
        test_reset_mid_hazard();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
